benes_pipe_permuter: RTL and testbench
======================================

// Module: benes_pipe_permuter
// PURPOSE
//  Pipelined, parametrised Benes permutation engine for the L1 Random Modulo index path.
//  It permutes an N-bit word under a 2*log2(N)-1 column switch key.
//  Adds a key register, a per-request forward/inverse mode, a tag pass-through and
//  valid/ready flow control with register ranks every PIPE_EVERY columns, so wide
//  indices meet timing.
// PARAMETERS
//  N          8  word width; power of 2, >= 2
//  PIPE_EVERY 1  switch columns between register ranks; >= 1
//  TAG_W      4  width of the opaque request tag carried alongside the word
//  Derived: L=log2(N); S=2L-1 columns; CNT=S*N/2 key bits; LAT=max(1,ceil(S/PIPE_EVERY))
// PORTS
//  clk       in   1      clock
//  reset     in   1      synchronous, active-high reset
//  key_load  in   1      load key_i into key register this cycle
//  key_i     in   CNT    new switch key; bit layout identical to benes_network control
//  in_valid  in   1      request present
//  in_ready  out  1      request accepted when in_valid && in_ready
//  in_word   in   N      word to permute
//  in_inv    in   1      0: forward permutation; 1: inverse permutation under same key
//  in_tag    in   TAG_W  opaque tag
//  out_valid out  1      result present
//  out_ready in   1      consumer accepts result
//  out_word  out  N      permuted word
//  out_tag   out  TAG_W  tag of the request
//  idle      out  1      no valid entry in any rank
// BEHAVIOUR
//  - Reset, any cycle including mid-operation: all rank valids=0, which drops in-flight
//    requests; key register=0 (identity permutation).
//    Outputs after reset: out_valid=0, out_word=0, out_tag=0, in_ready=1, idle=1.
//  - Forward result must equal benes_network(N,CNT) for the same word and key, bit-exact.
//    Inverse applies the columns in reverse order with the same per-column bits, so
//    inverse(forward(w))==w for every key.
//  - Key layout: the top-level N bits are key[CNT-1 -: N].
//    Even bit i is the entry switch of pair (i,i+1); odd bit i+1 is the exit switch.
//    The high subnet (odd lanes) uses the next CNT_H=(CNT-N)/2 bits, the low subnet
//    the lowest CNT_H bits, recursively.
//  - Key snapshot: each accepted request captures the full key, or the columns it still
//    needs, into its rank. key_load never alters in-flight requests.
//    If key_load and accept occur in the same cycle, the request uses key_i (bypass).
//  - Flow control: advance = !out_valid || out_ready; all ranks shift together on
//    advance; in_ready = advance (combinational from out_ready; no combinational path
//    from in_valid). Bubbles are not collapsed.
//  - Latency: accept at cycle t with no stalls -> out_valid at t+LAT. Throughput 1/cycle.
//  - While out_valid && !out_ready: out_word and out_tag hold stable; nothing is accepted.
//  - Last rank registers out_word/out_tag; out_word only updates on advance.
//  - idle = no rank valid (includes output rank).
// STRUCTURE
//  - Package: function benes_cnt(N) returning S*N/2, function benes_cols(N), and the typedef
//    of a pipeline rank {valid, word, inv, tag, key}.
//  - Iterative (column-flattened) datapath, not recursive. Precompute per column the lane
//    pairing and inter-column shuffle as constants (generate loops).
//  - Inverse mode selects column order at each rank via mux; the mode bit travels with the
//    request.
//  - One sub-module: benes_column (N lanes, N/2 2x2 switches plus fixed shuffle, combinational).
//    Instantiated S times.
// TESTING (N=8, CNT=20, PIPE_EVERY=1 -> LAT=5 unless stated)
//  1. Reset then key=0, in_word=0xA5 fwd -> out_word=0xA5 exactly 5 cycles after accept;
//     idle=0 during, 1 after.
//  2. key=1<<12 (top entry pair 0), in_word=0x01 -> 0x02;
//     key=(1<<12)|(1<<13) -> 0x01 (identity).
//  3. 1000 random key/word pairs, forward -> match benes_network golden model;
//     feed result with in_inv=1 -> original word returned.
//  4. Stream 8 words back-to-back; key_load=1 with new key on accept of word 4 ->
//     words 0-3 use old key, words 4-7 new key; tags emerge in order 0..7.
//  5. out_ready=0 for 3 cycles with full pipe -> in_ready=0, out_word/out_tag stable,
//     no loss or duplication; resume -> in-order completion.
//  6. Assert reset with 3 requests in flight -> next cycle out_valid=0, idle=1,
//     key=identity; none of the 3 ever appear.
//     Repeat 1 with PIPE_EVERY=5 -> LAT=1.

Source files
------------

// File: rtl/benes_pipe_permuter_pkg.sv
// Shared sizing and wiring helpers for the pipelined Benes permuter.
// All functions are constant-evaluable and are used at elaboration only.
package benes_pipe_permuter_pkg;

  // Number of switch columns: 2*log2(n)-1.
  function automatic int unsigned benes_cols(input int unsigned n);
    return 2 * $clog2(n) - 1;
  endfunction

  // Number of key bits: one per 2x2 switch.
  function automatic int unsigned benes_cnt(input int unsigned n);
    return benes_cols(n) * n / 2;
  endfunction

  // Recursion level a column belongs to: entry columns descend, exit columns climb back.
  function automatic int unsigned benes_level(input int unsigned n, input int unsigned col);
    int unsigned l;
    l = $clog2(n);
    return (col < l) ? col : 2 * l - 2 - col;
  endfunction

  // Key bit driving switch sw (lanes 2sw, 2sw+1 in stacked-subnet order) of column col.
  // Subnets are stacked low-half/high-half; a high subnet's key sits CNT_H above its parent.
  function automatic int unsigned benes_key_idx(input int unsigned n, input int unsigned col,
                                                input int unsigned sw);
    int unsigned d, m, s, j, base;
    d    = benes_level(n, col);
    m    = n >> d;
    s    = sw / (m / 2);
    j    = sw % (m / 2);
    base = 0;
    for (int unsigned k = 0; k < d; k++) begin
      if (((s >> (d - 1 - k)) & 1) != 0) base += benes_cnt(n >> (k + 1));
    end
    if (m == 2) return base;
    return base + benes_cnt(m) - m + 2 * j + ((col >= $clog2(n)) ? 1 : 0);
  endfunction

  // Source lane for lane q before the switches: exit columns re-interleave two subnets.
  function automatic int unsigned benes_pre_src(input int unsigned n, input int unsigned col,
                                                input int unsigned q);
    int unsigned m, r;
    if (col < $clog2(n)) return q;
    m = n >> benes_level(n, col);
    r = q % m;
    return (q - r) + (r % 2) * (m / 2) + r / 2;
  endfunction

  // Source lane for lane q after the switches: entry columns split even/odd lanes into
  // the low/high subnets.
  function automatic int unsigned benes_post_src(input int unsigned n, input int unsigned col,
                                                 input int unsigned q);
    int unsigned m, r;
    if (col + 1 >= $clog2(n)) return q;
    m = n >> col;
    r = q % m;
    return (q - r) + 2 * (r % (m / 2)) + r / (m / 2);
  endfunction

endpackage

// File: rtl/benes_pipe_permuter_if.sv
// Request/response handshake bundle of the Benes permuter.
interface benes_pipe_permuter_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_word;
  logic             in_inv;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_word;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_word, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_word, out_tag
  );

  modport slave (
    input  in_valid, in_word, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_word, out_tag
  );
endinterface

// File: rtl/benes_column.sv
// One Benes switch column: fixed pre-shuffle, N/2 2x2 switches, fixed post-shuffle.
module benes_column
  import benes_pipe_permuter_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned Col = 0
) (
  input  logic [N-1:0]   d_i,
  input  logic [N/2-1:0] sw_i,
  output logic [N-1:0]   d_o
);
  logic [N-1:0] pre_lanes;
  logic [N-1:0] mid_lanes;

  for (genvar q = 0; q < N; q++) begin : g_pre
    assign pre_lanes[q] = d_i[benes_pre_src(N, Col, q)];
  end

  for (genvar p = 0; p < N / 2; p++) begin : g_sw
    assign mid_lanes[2*p]   = sw_i[p] ? pre_lanes[2*p+1] : pre_lanes[2*p];
    assign mid_lanes[2*p+1] = sw_i[p] ? pre_lanes[2*p]   : pre_lanes[2*p+1];
  end

  for (genvar q = 0; q < N; q++) begin : g_post
    assign d_o[q] = mid_lanes[benes_post_src(N, Col, q)];
  end
endmodule

// File: rtl/benes_pipe_permuter.sv
// Pipelined Benes permuter: key register, per-request forward/inverse mode, tag
// pass-through and valid/ready flow control with a register rank every PIPE_EVERY columns.
module benes_pipe_permuter
  import benes_pipe_permuter_pkg::*;
#(
  parameter  int unsigned N          = 8,
  parameter  int unsigned PIPE_EVERY = 1,
  parameter  int unsigned TAG_W      = 4,
  localparam int unsigned CNT        = benes_cnt(N)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        key_load,
  input  logic [CNT-1:0]              key_i,
  benes_pipe_permuter_if.slave        bus,
  output logic                        idle
);
  localparam int unsigned S   = benes_cols(N);
  localparam int unsigned LAT = (S + PIPE_EVERY - 1) / PIPE_EVERY;

  typedef struct packed {
    logic             valid;
    logic [N-1:0]     word;
    logic             inv;
    logic [TAG_W-1:0] tag;
    logic [CNT-1:0]   key;
  } rank_t;

  rank_t          rank_q [LAT];
  rank_t          rank_d [LAT];
  rank_t          src    [LAT];  // what feeds the columns of each rank
  logic [CNT-1:0] key_q;
  logic [N-1:0]   col_in  [S];
  logic [N-1:0]   col_out [S];
  logic           advance;

  assign advance      = !rank_q[LAT-1].valid || bus.out_ready;
  assign bus.in_ready = advance;

  // A request accepted together with key_load snapshots the new key directly.
  assign src[0] = '{valid: bus.in_valid, word: bus.in_word, inv: bus.in_inv, tag: bus.in_tag,
                    key: key_load ? key_i : key_q};

  for (genvar c = 0; c < S; c++) begin : g_col
    localparam int unsigned R = c / PIPE_EVERY;
    logic [N/2-1:0] sw;
    // Inverse runs the columns mirrored: same wiring here, key bits of column S-1-c.
    for (genvar p = 0; p < N / 2; p++) begin : g_sel
      localparam int unsigned KeyFwd = benes_key_idx(N, c, p);
      localparam int unsigned KeyInv = benes_key_idx(N, S - 1 - c, p);
      assign sw[p] = src[R].inv ? src[R].key[KeyInv] : src[R].key[KeyFwd];
    end
    if (c % PIPE_EVERY == 0) begin : g_head
      assign col_in[c] = src[R].word;
    end else begin : g_chain
      assign col_in[c] = col_out[c-1];
    end
    benes_column #(
      .N  (N),
      .Col(c)
    ) u_col (
      .d_i (col_in[c]),
      .sw_i(sw),
      .d_o (col_out[c])
    );
  end

  for (genvar r = 0; r < LAT; r++) begin : g_rank
    localparam int unsigned LastCol = ((r + 1) * PIPE_EVERY < S) ? (r + 1) * PIPE_EVERY - 1
                                                                 : S - 1;
    if (r > 0) begin : g_src
      assign src[r] = rank_q[r-1];
    end
    assign rank_d[r] = '{valid: src[r].valid, word: col_out[LastCol], inv: src[r].inv,
                         tag: src[r].tag, key: src[r].key};
  end

  // Key register plus all ranks; ranks shift in lockstep, so bubbles stay in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= '0;
      for (int r = 0; r < LAT; r++) rank_q[r] <= '0;
    end else begin
      if (key_load) key_q <= key_i;
      if (advance) begin
        for (int r = 0; r < LAT; r++) rank_q[r] <= rank_d[r];
      end
    end
  end

  assign bus.out_valid = rank_q[LAT-1].valid;
  assign bus.out_word  = rank_q[LAT-1].word;
  assign bus.out_tag   = rank_q[LAT-1].tag;

  // Idle when no rank, including the output rank, holds a request.
  always_comb begin
    idle = 1'b1;
    for (int r = 0; r < LAT; r++) begin
      if (rank_q[r].valid) idle = 1'b0;
    end
  end
endmodule

// File: tb/tb_benes_pipe_permuter.sv
// Bench for benes_pipe_permuter (N=8): hand vectors, directed flow-control sequences and
// randomized traffic scored against a recursive Benes reference model.
module tb_benes_pipe_permuter;
  localparam int unsigned N   = 8;
  localparam int unsigned TW  = 4;
  localparam int unsigned CNT = 20;

  logic           clk = 1'b0;
  logic           reset;
  logic           key_load, key_load1;
  logic [CNT-1:0] key_i, key_i1;
  logic           idle, idle1;

  always #5 clk = ~clk;

  benes_pipe_permuter_if #(.N(N), .TAG_W(TW)) bus0 ();
  benes_pipe_permuter_if #(.N(N), .TAG_W(TW)) bus1 ();

  benes_pipe_permuter #(.N(N), .PIPE_EVERY(1), .TAG_W(TW)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_load(key_load),
    .key_i   (key_i),
    .bus     (bus0),
    .idle    (idle)
  );

  benes_pipe_permuter #(.N(N), .PIPE_EVERY(5), .TAG_W(TW)) dut_lat1 (
    .clk     (clk),
    .reset   (reset),
    .key_load(key_load1),
    .key_i   (key_i1),
    .bus     (bus1),
    .idle    (idle1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  typedef struct {
    logic [7:0] word;
    logic [3:0] tag;
  } exp_t;
  exp_t           sbq[$];
  logic [CNT-1:0] mkey;
  logic [7:0]     last_word;
  logic [3:0]     last_tag;

  typedef struct {
    logic [CNT-1:0] key;
    logic [7:0]     word;
    logic           inv;
    logic [7:0]     exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: Benes network by its recursive definition, one function per size.
  function automatic logic [1:0] ref2(input logic [1:0] w, input logic k);
    return k ? {w[0], w[1]} : w;
  endfunction

  function automatic logic [3:0] ref4(input logic [3:0] w, input logic [5:0] k);
    logic [3:0] t, x, y;
    logic [1:0] ev, od, lo, hi;
    t = k[5:2];
    x = w;
    for (int j = 0; j < 2; j++) begin
      if (t[2*j]) begin
        x[2*j]   = w[2*j+1];
        x[2*j+1] = w[2*j];
      end
      ev[j] = x[2*j];
      od[j] = x[2*j+1];
    end
    hi = ref2(od, k[1]);
    lo = ref2(ev, k[0]);
    for (int j = 0; j < 2; j++) begin
      y[2*j]   = t[2*j+1] ? hi[j] : lo[j];
      y[2*j+1] = t[2*j+1] ? lo[j] : hi[j];
    end
    return y;
  endfunction

  function automatic logic [7:0] ref8(input logic [7:0] w, input logic [19:0] k);
    logic [7:0] t, x, y;
    logic [3:0] ev, od, lo, hi;
    t = k[19:12];
    x = w;
    for (int j = 0; j < 4; j++) begin
      if (t[2*j]) begin
        x[2*j]   = w[2*j+1];
        x[2*j+1] = w[2*j];
      end
      ev[j] = x[2*j];
      od[j] = x[2*j+1];
    end
    hi = ref4(od, k[11:6]);
    lo = ref4(ev, k[5:0]);
    for (int j = 0; j < 4; j++) begin
      y[2*j]   = t[2*j+1] ? hi[j] : lo[j];
      y[2*j+1] = t[2*j+1] ? lo[j] : hi[j];
    end
    return y;
  endfunction

  // Inverse permutation: find where each input lane lands, then read it back from there.
  function automatic logic [7:0] ref_inv8(input logic [7:0] x, input logic [19:0] k);
    logic [7:0] r, oh, d;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      oh = 8'h01 << i;
      d  = ref8(oh, k);
      for (int j = 0; j < 8; j++) if (d[j]) r[i] = x[j];
    end
    return r;
  endfunction

  // One clock: drive at the falling edge, sample 1ns later, score handshakes.
  task automatic step(input logic v, input logic [7:0] w, input logic inv, input logic [3:0] tag,
                      input logic kl, input logic [19:0] k, input logic ordy,
                      input logic use_exp, input logic [7:0] exp_w, output logic acc);
    logic [19:0] kuse;
    exp_t        e;
    @(negedge clk);
    bus0.in_valid  = v;
    bus0.in_word   = w;
    bus0.in_inv    = inv;
    bus0.in_tag    = tag;
    bus0.out_ready = ordy;
    key_load       = kl;
    key_i          = k;
    #1;
    acc = v && bus0.in_ready;
    if (bus0.out_valid && ordy) begin
      n_out++;
      last_word = bus0.out_word;
      last_tag  = bus0.out_tag;
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got word 0x%0h tag %0d, expected no output",
                 bus0.out_word, bus0.out_tag);
      end else begin
        e = sbq.pop_front();
        check("sb_word", 32'(bus0.out_word), 32'(e.word));
        check("sb_tag", 32'(bus0.out_tag), 32'(e.tag));
      end
    end
    if (acc) begin
      kuse   = kl ? k : mkey;
      e.word = use_exp ? exp_w : (inv ? ref_inv8(w, kuse) : ref8(w, kuse));
      e.tag  = tag;
      sbq.push_back(e);
    end
    if (kl) mkey = k;
  endtask

  task automatic send(input logic [7:0] w, input logic inv, input logic [3:0] tag,
                      input logic kl, input logic [19:0] k, input logic use_exp,
                      input logic [7:0] exp_w);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      step(1'b1, w, inv, tag, kl, k, ($urandom_range(3) != 0), use_exp, exp_w, acc);
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: request tag %0d not accepted, expected accept", tag);
    end
  endtask

  task automatic drain(input string name);
    logic acc;
    for (int i = 0; i < 60 && sbq.size() > 0; i++) begin
      step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, '0, 1'b1, 1'b0, 8'h00, acc);
    end
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    key_load      = 1'b0;
    key_load1     = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    mkey = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic           acc;
    logic [19:0]    k, ka, kb;
    logic [7:0]     w, fw, hold_w;
    logic [3:0]     hold_t;
    int             n0;

    vecs[0] = '{key: 20'h0,             word: 8'hA5, inv: 1'b0, exp: 8'hA5};
    vecs[1] = '{key: 20'h1 << 12,       word: 8'h01, inv: 1'b0, exp: 8'h02};
    vecs[2] = '{key: 20'h3 << 12,       word: 8'h01, inv: 1'b0, exp: 8'h01};
    vecs[3] = '{key: 20'h1 << 13,       word: 8'h01, inv: 1'b0, exp: 8'h02};
    vecs[4] = '{key: 20'h1,             word: 8'h01, inv: 1'b0, exp: 8'h10};
    vecs[5] = '{key: 20'h1,             word: 8'h10, inv: 1'b1, exp: 8'h01};
    vecs[6] = '{key: 20'h1 << 12,       word: 8'h02, inv: 1'b1, exp: 8'h01};
    vecs[7] = '{key: 20'h1 << 13,       word: 8'h02, inv: 1'b1, exp: 8'h01};

    reset          = 1'b1;
    key_load       = 1'b0;
    key_i          = '0;
    key_load1      = 1'b0;
    key_i1         = '0;
    mkey           = '0;
    bus0.in_valid  = 1'b0;
    bus0.in_word   = '0;
    bus0.in_inv    = 1'b0;
    bus0.in_tag    = '0;
    bus0.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_word   = '0;
    bus1.in_inv    = 1'b0;
    bus1.in_tag    = '0;
    bus1.out_ready = 1'b1;
    do_reset();
    #1;
    check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst_out_word", 32'(bus0.out_word), 32'd0);
    check("rst_out_tag", 32'(bus0.out_tag), 32'd0);
    check("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);

    // Identity key, exact latency and idle profile.
    step(1'b1, 8'hA5, 1'b0, 4'h3, 1'b0, '0, 1'b1, 1'b1, 8'hA5, acc);
    check("lat_accept", 32'(acc), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, '0, 1'b1, 1'b0, 8'h00, acc);
      check("lat_out_valid", 32'(bus0.out_valid), 32'(i == 5));
      check("lat_idle", 32'(idle), 32'(i >= 6));
    end
    check("lat_word", 32'(last_word), 32'hA5);

    // Hand-derived vectors, key supplied through the load bypass.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].word, vecs[i].inv, 4'(i), 1'b1, vecs[i].key, 1'b1, 1'b1, vecs[i].exp,
           acc);
      check("vec_accept", 32'(acc), 32'd1);
      drain("vec_drain");
      check("vec_word", 32'(last_word), 32'(vecs[i].exp));
    end

    // Random forward against the model, then the result fed back inverse must return w.
    for (int i = 0; i < 1000; i++) begin
      k  = 20'($urandom);
      w  = 8'($urandom);
      fw = ref8(w, k);
      if ($urandom_range(3) == 0) begin
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, '0, 1'b1, 1'b0, 8'h00, acc);
      end
      send(w, 1'b0, 4'(2 * i), 1'b1, k, 1'b0, 8'h00);
      send(fw, 1'b1, 4'(2 * i + 1), 1'b0, '0, 1'b1, w);
      if ($urandom_range(3) == 0) send(8'($urandom), 1'b1, 4'hE, 1'b0, '0, 1'b0, 8'h00);
    end
    drain("rand_drain");

    // Back-to-back stream with a key change on the fifth accept.
    ka = 20'($urandom) | 20'h1000;
    kb = 20'($urandom) | 20'h0001;
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      k = (i < 4) ? ka : kb;
      step(1'b1, 8'($urandom), 1'b0, 4'(i), (i == 0 || i == 4), k, 1'b1, 1'b0, 8'h00, acc);
      check("stream_accept", 32'(acc), 32'd1);
    end
    drain("stream_drain");
    check("stream_count", 32'(n_out - n0), 32'd8);
    check("stream_last_tag", 32'(last_tag), 32'd7);

    // Fill the pipe with out_ready low, hold it for three cycles, then release.
    n0 = n_out;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 4'(i), 1'b0, '0, 1'b0, 1'b0, 8'h00, acc);
      check("fill_accept", 32'(acc), 32'd1);
    end
    hold_w = 8'h00;
    hold_t = 4'h0;
    for (int s = 0; s < 3; s++) begin
      step(1'b1, 8'($urandom), 1'b0, 4'hF, 1'b0, '0, 1'b0, 1'b0, 8'h00, acc);
      check("stall_accept", 32'(acc), 32'd0);
      check("stall_in_ready", 32'(bus0.in_ready), 32'd0);
      check("stall_out_valid", 32'(bus0.out_valid), 32'd1);
      if (s == 0) begin
        hold_w = bus0.out_word;
        hold_t = bus0.out_tag;
        check("stall_first_tag", 32'(bus0.out_tag), 32'd0);
      end else begin
        check("stall_word_hold", 32'(bus0.out_word), 32'(hold_w));
        check("stall_tag_hold", 32'(bus0.out_tag), 32'(hold_t));
      end
    end
    drain("stall_drain");
    check("stall_count", 32'(n_out - n0), 32'd5);
    check("stall_last_tag", 32'(last_tag), 32'd4);

    // Reset with three requests in flight under a non-identity key.
    k = 20'($urandom) | 20'h0_1001;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 4'(9 + i), (i == 0), k, 1'b1, 1'b0, 8'h00, acc);
      check("flight_accept", 32'(acc), 32'd1);
    end
    do_reset();
    #1;
    check("midrst_out_valid", 32'(bus0.out_valid), 32'd0);
    check("midrst_idle", 32'(idle), 32'd1);
    check("midrst_in_ready", 32'(bus0.in_ready), 32'd1);
    check("midrst_out_tag", 32'(bus0.out_tag), 32'd0);
    step(1'b1, 8'hA5, 1'b0, 4'h1, 1'b0, '0, 1'b1, 1'b1, 8'hA5, acc);
    step(1'b1, 8'h3C, 1'b1, 4'h2, 1'b0, '0, 1'b1, 1'b1, 8'h3C, acc);
    drain("midrst_drain");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, '0, 1'b1, 1'b0, 8'h00, acc);
    end
    check("midrst_quiet_idle", 32'(idle), 32'd1);

    // PIPE_EVERY=5 instance: single rank, one-cycle latency.
    @(negedge clk);
    bus1.in_valid  = 1'b1;
    bus1.in_word   = 8'hA5;
    bus1.in_inv    = 1'b0;
    bus1.in_tag    = 4'h5;
    bus1.out_ready = 1'b1;
    #1;
    check("l1_in_ready", 32'(bus1.in_ready), 32'd1);
    check("l1_pre_valid", 32'(bus1.out_valid), 32'd0);
    @(negedge clk);
    bus1.in_word = 8'h01;
    bus1.in_tag  = 4'h6;
    key_load1    = 1'b1;
    key_i1       = 20'h1 << 12;
    #1;
    check("l1_out_valid", 32'(bus1.out_valid), 32'd1);
    check("l1_out_word", 32'(bus1.out_word), 32'hA5);
    check("l1_out_tag", 32'(bus1.out_tag), 32'd5);
    check("l1_busy", 32'(idle1), 32'd0);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    key_load1     = 1'b0;
    #1;
    check("l1_key_word", 32'(bus1.out_word), 32'h02);
    check("l1_key_tag", 32'(bus1.out_tag), 32'd6);
    @(negedge clk);
    #1;
    check("l1_done_valid", 32'(bus1.out_valid), 32'd0);
    check("l1_done_idle", 32'(idle1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
